// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP status/ack transmit path and its
// receive-side sibling udp_panel_writer.
package udp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } tx_state_t;

  localparam int PAYLOAD_WORDS = 4;
  localparam int PAYLOAD_BYTES = 16;

  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd6001;
  localparam logic [15:0] DEFAULT_RX_PORT  = 16'd6000;
  localparam logic [31:0] DEFAULT_MAGIC    = 32'h4C454441;

  // One queued request: where to send and which sequence number to echo.
  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] port;
    logic [31:0] seq;
  } req_t;

  // Everything the payload needs, frozen at packet start.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] frame;
    logic [15:0] err;
    logic [15:0] drop;
  } snap_t;

  function automatic logic [31:0] payload_word(input logic [1:0]  idx,
                                               input logic [31:0] magic,
                                               input snap_t       s);
    case (idx)
      2'd0:    return magic;
      2'd1:    return s.seq;
      2'd2:    return s.frame;
      default: return {s.err, s.drop};
    endcase
  endfunction

endpackage

// File: rtl/udp_req_slot.sv
// One-deep request holding slot. A newer request overwrites an unconsumed
// one and bumps a saturating drop counter.
module udp_req_slot
  import udp_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  req_t        req_in,
  input  logic        consume,
  output logic        pending,
  output req_t        slot,
  output logic [15:0] drop_count
);

  // An overrun only counts when the slot still holds an unsent request;
  // a request landing in the consume cycle simply refills the slot.
  logic overrun;
  assign overrun = req && pending && !consume;

  // NOTE: every flop here uses <= so all registers update from the same
  // pre-edge values; blocking '=' would let later statements see new values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending    <= 1'b0;
      slot       <= '0;
      drop_count <= '0;
    end else begin
      if (req) begin
        slot    <= req_in;
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
      if (overrun && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: rtl/udp_status_sender.sv
// Emits one fixed 4-word status/ack UDP datagram per request onto the
// liteeth udp_sink stream, with counters snapshotted at packet start.
module udp_status_sender
  import udp_pkg::*;
#(
  parameter logic [15:0] SRC_PORT = DEFAULT_SRC_PORT,
  parameter logic [31:0] MAGIC    = DEFAULT_MAGIC,
  parameter int          MIN_GAP  = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] req_ip,
  input  logic [15:0] req_port,
  input  logic [31:0] req_seq,
  input  logic [31:0] frame_count,
  input  logic [15:0] err_count,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic [3:0]  udp_sink_error,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_WORDS - 1);
  localparam logic [7:0] GAP_LAST = 8'(MIN_GAP - 1);

  tx_state_t   state;
  logic        pending;
  req_t        req_in;
  req_t        slot;
  snap_t       snap;
  logic [1:0]  beat_idx;
  logic [1:0]  next_idx;
  logic [7:0]  gap_cnt;
  logic        xfer;

  assign req_in   = '{ip: req_ip, port: req_port, seq: req_seq};
  assign next_idx = beat_idx + 2'd1;
  assign xfer     = udp_sink_valid && udp_sink_ready;

  udp_req_slot u_slot (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .req_in     (req_in),
    .consume    (state == ST_LOAD),
    .pending    (pending),
    .slot       (slot),
    .drop_count (drop_count)
  );

  assign udp_sink_src_port = SRC_PORT;
  assign udp_sink_length   = 16'(PAYLOAD_BYTES);
  assign udp_sink_error    = 4'b0000;
  assign busy              = (state != ST_IDLE) || pending;

  // Stream outputs only change in LOAD or on an accepted beat, which keeps
  // them stable across arbitrarily long backpressure.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state               <= ST_IDLE;
      udp_sink_valid      <= 1'b0;
      udp_sink_last       <= 1'b0;
      udp_sink_data       <= '0;
      udp_sink_ip_address <= '0;
      udp_sink_dst_port   <= '0;
      snap                <= '0;
      beat_idx            <= '0;
      gap_cnt             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_LOAD;
        end
        ST_LOAD: begin
          udp_sink_ip_address <= slot.ip;
          udp_sink_dst_port   <= slot.port;
          snap.seq            <= slot.seq;
          snap.frame          <= frame_count;
          snap.err            <= err_count;
          snap.drop           <= drop_count;
          udp_sink_data       <= MAGIC;
          udp_sink_last       <= 1'b0;
          udp_sink_valid      <= 1'b1;
          beat_idx            <= '0;
          state               <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            if (beat_idx == LAST_IDX) begin
              udp_sink_valid <= 1'b0;
              udp_sink_last  <= 1'b0;
              gap_cnt        <= '0;
              state          <= ST_GAP;
            end else begin
              beat_idx      <= next_idx;
              udp_sink_data <= payload_word(next_idx, MAGIC, snap);
              udp_sink_last <= (next_idx == LAST_IDX);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_status_sender.sv
// Scoreboard bench for udp_status_sender: expected beats are queued when a
// request is driven and compared as the stream delivers them.
module tb_udp_status_sender;

  localparam int          MIN_GAP = 8;
  localparam logic [31:0] MAGIC   = 32'h4C454441;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] ip;
    logic [15:0] port;
  } beat_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic [31:0] req_ip = '0;
  logic [15:0] req_port = '0;
  logic [31:0] req_seq = '0;
  logic [31:0] frame_count = '0;
  logic [15:0] err_count = '0;
  logic        udp_sink_valid;
  logic        udp_sink_last;
  logic        udp_sink_ready = 1'b0;
  logic [15:0] udp_sink_src_port;
  logic [15:0] udp_sink_dst_port;
  logic [31:0] udp_sink_ip_address;
  logic [15:0] udp_sink_length;
  logic [31:0] udp_sink_data;
  logic [3:0]  udp_sink_error;
  logic        busy;
  logic [15:0] drop_count;

  udp_status_sender #(.MIN_GAP(MIN_GAP)) dut (
    .clock               (clock),
    .resetn              (resetn),
    .req                 (req),
    .req_ip              (req_ip),
    .req_port            (req_port),
    .req_seq             (req_seq),
    .frame_count         (frame_count),
    .err_count           (err_count),
    .udp_sink_valid      (udp_sink_valid),
    .udp_sink_last       (udp_sink_last),
    .udp_sink_ready      (udp_sink_ready),
    .udp_sink_src_port   (udp_sink_src_port),
    .udp_sink_dst_port   (udp_sink_dst_port),
    .udp_sink_ip_address (udp_sink_ip_address),
    .udp_sink_length     (udp_sink_length),
    .udp_sink_data       (udp_sink_data),
    .udp_sink_error      (udp_sink_error),
    .busy                (busy),
    .drop_count          (drop_count)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus driver for ready and frame_count, updated just after each edge.
  logic        bp_mode = 1'b0;
  int          bp_k = 0;
  logic        ready_level = 1'b0;
  logic        frame_inc = 1'b0;
  logic [31:0] frame_base = '0;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode) begin
        udp_sink_ready = (bp_k >= 6 && bp_k < 26) ? 1'b0 : bp_k[0];
        bp_k++;
      end else begin
        udp_sink_ready = ready_level;
        bp_k = 0;
      end
      frame_count = frame_inc ? frame_base + cyc : frame_base;
    end
  end

  // Scoreboard and stream monitor, sampled on the falling edge.
  beat_t       sb_q[$];
  int          xfer_cnt = 0;
  int unsigned first_valid_cyc = 0;
  int unsigned last_xfer_cyc = 0;
  int unsigned last_gap = 0;
  int          stall_run = 0;
  int          max_stall = 0;
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       held;

  always @(negedge clock) begin
    if (!resetn) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      stall_run  = 0;
    end else begin
      if (udp_sink_valid && !prev_valid) begin
        first_valid_cyc = cyc;
        last_gap        = cyc - last_xfer_cyc;
      end
      if (prev_stall) begin
        check("stall_valid", {63'd0, udp_sink_valid}, 64'd1);
        check("stall_data",  {32'd0, udp_sink_data}, {32'd0, held.data});
        check("stall_last",  {63'd0, udp_sink_last}, {63'd0, held.last});
        check("stall_ip",    {32'd0, udp_sink_ip_address}, {32'd0, held.ip});
      end
      if (udp_sink_valid && udp_sink_ready) begin
        xfer_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          check("beat_data", {32'd0, udp_sink_data}, {32'd0, e.data});
          check("beat_last", {63'd0, udp_sink_last}, {63'd0, e.last});
          check("beat_ip",   {32'd0, udp_sink_ip_address}, {32'd0, e.ip});
          check("beat_port", {48'd0, udp_sink_dst_port}, {48'd0, e.port});
          check("beat_len",  {48'd0, udp_sink_length}, 64'd16);
        end
        if (udp_sink_last) last_xfer_cyc = cyc;
      end
      if (udp_sink_valid && !udp_sink_ready) begin
        stall_run++;
        if (stall_run > max_stall) max_stall = stall_run;
      end else begin
        stall_run = 0;
      end
      prev_stall = udp_sink_valid && !udp_sink_ready;
      held       = '{udp_sink_data, udp_sink_last, udp_sink_ip_address, udp_sink_dst_port};
      prev_valid = udp_sink_valid;
    end
  end

  task automatic push_pkt(input logic [31:0] ip, input logic [15:0] port,
                          input logic [31:0] seq, input logic [31:0] frame,
                          input logic [15:0] err, input logic [15:0] drop);
    sb_q.push_back('{MAGIC,         1'b0, ip, port});
    sb_q.push_back('{seq,           1'b0, ip, port});
    sb_q.push_back('{frame,         1'b0, ip, port});
    sb_q.push_back('{{err, drop},   1'b1, ip, port});
  endtask

  int unsigned req_cyc = 0;

  task automatic do_req(input logic [31:0] ip, input logic [15:0] port, input logic [31:0] seq);
    @(posedge clock);
    #1;
    req = 1'b1; req_ip = ip; req_port = port; req_seq = seq;
    req_cyc = cyc;
    @(posedge clock);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_xfers(input string tag, input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!udp_sink_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", {63'd0, udp_sink_valid}, 64'd0);
    check("rst_last",  {63'd0, udp_sink_last}, 64'd0);
    check("rst_data",  {32'd0, udp_sink_data}, 64'd0);
    check("rst_ip",    {32'd0, udp_sink_ip_address}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_drop",  {48'd0, drop_count}, 64'd0);
    check("src_port",  {48'd0, udp_sink_src_port}, 64'd6001);
    check("error",     {60'd0, udp_sink_error}, 64'd0);
    check("length",    {48'd0, udp_sink_length}, 64'd16);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    // Single request, full-rate ready
    ready_level = 1'b1; frame_base = 32'd100; err_count = 16'd2;
    repeat (2) @(posedge clock);
    xfer_cnt = 0;
    push_pkt(32'hC0A80132, 16'd1234, 32'd7, 32'd100, 16'd2, 16'd0);
    do_req(32'hC0A80132, 16'd1234, 32'd7);
    wait_idle("single", 100);
    check("single_latency", 64'(first_valid_cyc - req_cyc), 64'd3);
    check("single_xfers", 64'(xfer_cnt), 64'd4);

    // Backpressure with a 20-cycle stall mid-packet
    frame_base = 32'h1234; err_count = 16'd5;
    bp_mode = 1'b1;
    xfer_cnt = 0; max_stall = 0;
    push_pkt(32'h0A000001, 16'd4000, 32'h22, 32'h1234, 16'd5, 16'd0);
    do_req(32'h0A000001, 16'd4000, 32'h22);
    wait_idle("bp", 200);
    bp_mode = 1'b0;
    check("bp_xfers", 64'(xfer_cnt), 64'd4);
    check("bp_long_stall", {63'd0, max_stall >= 20}, 64'd1);

    // Overrun: two requests while the first packet is stalled
    ready_level = 1'b0; frame_base = 32'd200; err_count = 16'd3;
    repeat (2) @(posedge clock);
    xfer_cnt = 0;
    push_pkt(32'h0A000002, 16'd5000, 32'h10, 32'd200, 16'd3, 16'd0);
    do_req(32'h0A000002, 16'd5000, 32'h10);
    wait_valid("ovr_first", 50);
    do_req(32'h0A000003, 16'd5001, 32'd8);
    do_req(32'h0A000004, 16'd5002, 32'd9);
    @(negedge clock);
    check("ovr_drop", {48'd0, drop_count}, 64'd1);
    check("ovr_busy", {63'd0, busy}, 64'd1);
    push_pkt(32'h0A000004, 16'd5002, 32'd9, 32'd200, 16'd3, 16'd1);
    ready_level = 1'b1;
    wait_idle("ovr", 200);
    check("ovr_xfers", 64'(xfer_cnt), 64'd8);
    check("ovr_gap_min", {63'd0, last_gap >= MIN_GAP + 2}, 64'd1);

    // Snapshot stability: frame_count moves every cycle
    frame_base = 32'h5000; frame_inc = 1'b1; err_count = 16'd9;
    repeat (2) @(posedge clock);
    xfer_cnt = 0;
    @(posedge clock);
    #1;
    req = 1'b1; req_ip = 32'h0A000005; req_port = 16'd6002; req_seq = 32'h33;
    req_cyc = cyc;
    push_pkt(32'h0A000005, 16'd6002, 32'h33, 32'h5000 + req_cyc + 2, 16'd9, 16'd1);
    @(posedge clock);
    #1;
    req = 1'b0;
    wait_idle("snap", 100);
    frame_inc = 1'b0;
    check("snap_xfers", 64'(xfer_cnt), 64'd4);

    // Reset mid-packet
    ready_level = 1'b1; frame_base = 32'd300; err_count = 16'd1;
    repeat (2) @(posedge clock);
    xfer_cnt = 0;
    push_pkt(32'h0A000006, 16'd7000, 32'h44, 32'd300, 16'd1, 16'd1);
    do_req(32'h0A000006, 16'd7000, 32'h44);
    wait_xfers("rst_mid", 2, 50);
    #2;
    resetn = 1'b0;
    sb_q.delete();
    #1;
    check("rstmid_valid", {63'd0, udp_sink_valid}, 64'd0);
    check("rstmid_busy",  {63'd0, busy}, 64'd0);
    check("rstmid_drop",  {48'd0, drop_count}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    xfer_cnt = 0;
    push_pkt(32'h0A000007, 16'd7001, 32'h45, 32'd300, 16'd1, 16'd0);
    do_req(32'h0A000007, 16'd7001, 32'h45);
    wait_idle("post_rst", 100);
    check("post_rst_xfers", 64'(xfer_cnt), 64'd4);

    // Drop saturation with the stream held off
    ready_level = 1'b0;
    repeat (2) @(posedge clock);
    do_req(32'h0A000008, 16'd7002, 32'h46);
    wait_valid("sat_first", 50);
    @(posedge clock);
    #1;
    req = 1'b1;
    repeat (65000) @(posedge clock);
    @(negedge clock);
    check("sat_mid", {48'd0, drop_count}, 64'd64999);
    repeat (5000) @(posedge clock);
    #1;
    req = 1'b0;
    @(negedge clock);
    check("sat_full", {48'd0, drop_count}, 64'hFFFF);
    check("sat_valid_held", {63'd0, udp_sink_valid}, 64'd1);
    apply_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
